// File: rtl/noc_mem_bridge_pkg.sv
// Shared types and default widths for the NoC-to-memory bridge.
package noc_mem_pkg;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;
   localparam int ID_W   = 4;
   localparam int TAG_W  = 4;

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;

   typedef struct packed {
      logic                  write;
      logic [ADDR_W-1:0]     addr;
      logic [DATA_W/8-1:0]   be;
      logic [DATA_W-1:0]     wdata;
      logic [ID_W-1:0]       src;
      logic [TAG_W-1:0]      tag;
   } req_t;

endpackage

// File: rtl/noc_mem_bridge_if.sv
// NoC local-port request/response and Avalon-style memory signals of the bridge.
// slave = bridge side, master = NoC router plus memory environment.
interface noc_mem_bridge_if #(
   parameter int ADDR_W = noc_mem_pkg::ADDR_W,
   parameter int DATA_W = noc_mem_pkg::DATA_W,
   parameter int ID_W   = noc_mem_pkg::ID_W,
   parameter int TAG_W  = noc_mem_pkg::TAG_W
);
   logic                  req_valid, req_ready, req_write;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W/8-1:0]   req_be;
   logic [DATA_W-1:0]     req_wdata;
   logic [ID_W-1:0]       req_src;
   logic [TAG_W-1:0]      req_tag;
   logic                  rsp_valid, rsp_ready, rsp_is_wr;
   logic [DATA_W-1:0]     rsp_data;
   logic [ID_W-1:0]       rsp_dst;
   logic [TAG_W-1:0]      rsp_tag;
   logic [ADDR_W-1:0]     mem_address;
   logic [DATA_W/8-1:0]   mem_byteenable;
   logic                  mem_chipselect, mem_write, mem_clken;
   logic [DATA_W-1:0]     mem_writedata, mem_readdata;

   modport slave (
      input  req_valid, req_write, req_addr, req_be, req_wdata, req_src, req_tag,
             rsp_ready, mem_readdata,
      output req_ready, rsp_valid, rsp_data, rsp_dst, rsp_tag, rsp_is_wr,
             mem_address, mem_byteenable, mem_chipselect, mem_write,
             mem_writedata, mem_clken
   );

   modport master (
      output req_valid, req_write, req_addr, req_be, req_wdata, req_src, req_tag,
             rsp_ready, mem_readdata,
      input  req_ready, rsp_valid, rsp_data, rsp_dst, rsp_tag, rsp_is_wr,
             mem_address, mem_byteenable, mem_chipselect, mem_write,
             mem_writedata, mem_clken
   );
endinterface

// File: rtl/noc_mem_bridge.sv
// Single-outstanding NoC endpoint driving a one-cycle-latency memory slave.
// Optional macro NOC_MEM_BRIDGE_WRITE_ACK_EN: writes return an ack response.
module noc_mem_bridge #(
   parameter int ADDR_W = noc_mem_pkg::ADDR_W,
   parameter int DATA_W = noc_mem_pkg::DATA_W,
   parameter int ID_W   = noc_mem_pkg::ID_W,
   parameter int TAG_W  = noc_mem_pkg::TAG_W
) (
   input  logic              clk,
   input  logic              reset,
   noc_mem_bridge_if.slave   bus
);
   import noc_mem_pkg::*;

   localparam int BE_W = DATA_W / 8;

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [BE_W-1:0]   be;
      logic [DATA_W-1:0] wdata;
      logic [ID_W-1:0]   src;
      logic [TAG_W-1:0]  tag;
   } breq_t;

   state_e            state_q, state_d;
   breq_t             req_q, req_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic [ID_W-1:0]   rsp_dst_q, rsp_dst_d;
   logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.req_valid) state_d = ISSUE;
`ifdef NOC_MEM_BRIDGE_WRITE_ACK_EN
         ISSUE:   state_d = req_q.write ? RESP : CAPTURE;
`else
         ISSUE:   state_d = req_q.write ? IDLE : CAPTURE;
`endif
         CAPTURE: state_d = RESP;
         RESP:    if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

`ifdef NOC_MEM_BRIDGE_WRITE_ACK_EN
   logic rsp_is_wr_q, rsp_is_wr_d;
`endif

   always_comb begin
      req_d      = req_q;
      rsp_data_d = rsp_data_q;
      rsp_dst_d  = rsp_dst_q;
      rsp_tag_d  = rsp_tag_q;
`ifdef NOC_MEM_BRIDGE_WRITE_ACK_EN
      rsp_is_wr_d = rsp_is_wr_q;
`endif
      bus.req_ready      = (state_q == IDLE) && !reset;
      bus.mem_chipselect = (state_q == ISSUE) && !reset;
      bus.mem_write      = (state_q == ISSUE) && !reset && req_q.write;
      unique case (state_q)
         IDLE: if (bus.req_valid) begin
            req_d = '{write: bus.req_write, addr: bus.req_addr, be: bus.req_be,
                      wdata: bus.req_wdata, src: bus.req_src, tag: bus.req_tag};
         end
`ifdef NOC_MEM_BRIDGE_WRITE_ACK_EN
         ISSUE: if (req_q.write) begin
            rsp_data_d  = '0;
            rsp_dst_d   = req_q.src;
            rsp_tag_d   = req_q.tag;
            rsp_is_wr_d = 1'b1;
         end
`endif
         CAPTURE: begin
            rsp_data_d = bus.mem_readdata;
            rsp_dst_d  = req_q.src;
            rsp_tag_d  = req_q.tag;
`ifdef NOC_MEM_BRIDGE_WRITE_ACK_EN
            rsp_is_wr_d = 1'b0;
`endif
         end
         default: ;
      endcase
   end

   // Response fields only load on CAPTURE/ISSUE, so they hold while RESP is backpressured.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_q      <= '0;
         rsp_data_q <= '0;
         rsp_dst_q  <= '0;
         rsp_tag_q  <= '0;
`ifdef NOC_MEM_BRIDGE_WRITE_ACK_EN
         rsp_is_wr_q <= 1'b0;
`endif
      end else begin
         req_q      <= req_d;
         rsp_data_q <= rsp_data_d;
         rsp_dst_q  <= rsp_dst_d;
         rsp_tag_q  <= rsp_tag_d;
`ifdef NOC_MEM_BRIDGE_WRITE_ACK_EN
         rsp_is_wr_q <= rsp_is_wr_d;
`endif
      end
   end

`ifdef NOC_MEM_BRIDGE_WRITE_ACK_EN
   assign bus.rsp_is_wr = rsp_is_wr_q;
`else
   assign bus.rsp_is_wr = 1'b0;
`endif

   assign bus.rsp_valid      = (state_q == RESP);
   assign bus.rsp_data       = rsp_data_q;
   assign bus.rsp_dst        = rsp_dst_q;
   assign bus.rsp_tag        = rsp_tag_q;
   assign bus.mem_address    = req_q.addr;
   assign bus.mem_byteenable = req_q.write ? req_q.be : {BE_W{1'b1}};
   assign bus.mem_writedata  = req_q.wdata;
   assign bus.mem_clken      = !reset;

endmodule
